// File: rtl/core_pkg.sv
// Shared core constants and types: fetch widths, reset PC, fetch FSM encoding
// and the {pc, insn} queue entry used between fetch and decode.
package core_pkg;

    localparam int PC_W        = 16;
    localparam int ADDR_W      = 6;
    localparam int INSN_W      = 32;
    localparam int FETCH_DEPTH = 4;

    localparam logic [PC_W-1:0] RESET_PC = PC_W'(10);

    // Encoding is visible to pipeline control, so keep values fixed.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INSN_W-1:0] insn;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] icache_index(input logic [PC_W-1:0] pc);
        return pc[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction queue between fetch and decode. Head is read combinationally
// from storage through a registered read pointer; flush empties it in one cycle.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head_entry,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop on an empty queue is ignored; a push into a full queue only lands
    // if the head leaves in the same cycle.
    assign do_pop     = pop && (count != '0);
    assign do_push    = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head_entry = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clk_en) begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= push_entry;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (do_push && !do_pop) begin
                    count <= count + 1'b1;
                end else if (!do_push && do_pop) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single outstanding icache reads,
// queues returned words with their PC and handles redirect flush/drain.
module fetch_unit
    import core_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    output logic              icache_req,
    output logic [ADDR_W-1:0] icache_read_addr,
    input  logic [INSN_W-1:0] icache_read_data,
    input  logic              icache_data_ready,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              insn_valid,
    output logic [INSN_W-1:0] insn_data,
    output logic [PC_W-1:0]   insn_pc,
    input  logic              insn_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t     state;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  req_pc;
    logic             drop;
    logic [CNT_W-1:0] count;
    logic             outstanding;
    logic             credit_ok;
    logic             push;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    // Credit reserves a slot for the in-flight word so a return never sees a full queue.
    assign outstanding = (state != IDLE);
    assign credit_ok   = ({1'b0, count} + {{CNT_W{1'b0}}, outstanding}) < (CNT_W+1)'(DEPTH);

    assign push       = (state == WAIT) && icache_data_ready && !drop && !redirect_valid;
    assign push_entry = '{pc: req_pc, insn: icache_read_data};
    assign insn_valid = (count != '0);
    assign pop        = insn_valid && insn_ready;
    assign insn_pc    = head_entry.pc;
    assign insn_data  = head_entry.insn;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head_entry (head_entry),
        .count      (count)
    );

    // Redirect beats everything; an in-flight read either returns this cycle
    // (discarded) or is drained later with the drop flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            pc               <= RESET_PC;
            req_pc           <= '0;
            drop             <= 1'b0;
            icache_req       <= 1'b0;
            icache_read_addr <= '0;
        end else if (clk_en) begin
            icache_req <= 1'b0;
            if (redirect_valid) begin
                pc <= redirect_pc;
                if (state != IDLE) begin
                    if (icache_data_ready) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                    end else begin
                        state <= DRAIN;
                        drop  <= 1'b1;
                    end
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (credit_ok) begin
                            icache_req       <= 1'b1;
                            icache_read_addr <= icache_index(pc);
                            req_pc           <= pc;
                            pc               <= pc + 1'b1;
                            state            <= WAIT;
                        end
                    end
                    WAIT, DRAIN: begin
                        if (icache_data_ready) begin
                            state <= IDLE;
                            drop  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        drop  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: clock-enabled icache responder with
// programmable latency plus an in-order PC/fetch-address reference model.
module tb_fetch_unit;
    import core_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clk_en = 1'b1;
    logic              icache_req;
    logic [ADDR_W-1:0] icache_read_addr;
    logic [INSN_W-1:0] icache_read_data;
    logic              icache_data_ready;
    logic              redirect_valid = 1'b0;
    logic [PC_W-1:0]   redirect_pc = '0;
    logic              insn_valid;
    logic [INSN_W-1:0] insn_data;
    logic [PC_W-1:0]   insn_pc;
    logic              insn_ready = 1'b0;

    fetch_unit dut (
        .clk               (clk),
        .rst               (rst),
        .clk_en            (clk_en),
        .icache_req        (icache_req),
        .icache_read_addr  (icache_read_addr),
        .icache_read_data  (icache_read_data),
        .icache_data_ready (icache_data_ready),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .insn_valid        (insn_valid),
        .insn_data         (insn_data),
        .insn_pc           (insn_pc),
        .insn_ready        (insn_ready)
    );

    always #5 clk = ~clk;

    logic [INSN_W-1:0] imem [64];
    int                latency = 1;
    logic              ic_busy;
    int                ic_cnt;
    logic [ADDR_W-1:0] ic_addr;

    // Icache responder shares clk_en, answers the sampled request `latency` edges later.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            icache_data_ready <= 1'b0;
            icache_read_data  <= '0;
            ic_busy           <= 1'b0;
            ic_cnt            <= 0;
            ic_addr           <= '0;
        end else if (clk_en) begin
            icache_data_ready <= 1'b0;
            if (icache_req && !ic_busy) begin
                ic_addr <= icache_read_addr;
                if (latency <= 1) begin
                    icache_data_ready <= 1'b1;
                    icache_read_data  <= imem[icache_read_addr];
                end else begin
                    ic_busy <= 1'b1;
                    ic_cnt  <= latency - 1;
                end
            end else if (ic_busy) begin
                if (ic_cnt == 1) begin
                    icache_data_ready <= 1'b1;
                    icache_read_data  <= imem[ic_addr];
                    ic_busy           <= 1'b0;
                end else begin
                    ic_cnt <= ic_cnt - 1;
                end
            end
        end
    end

    int              errors = 0;
    int              checks = 0;
    int              pops = 0;
    int              reqs = 0;
    logic            rand_ready = 1'b0;
    logic [PC_W-1:0] exp_pc = RESET_PC;
    logic [PC_W-1:0] exp_fetch = RESET_PC;
    logic [55:0]     snap;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [55:0] outputs_now();
        return {icache_req, icache_read_addr, insn_valid, insn_pc, insn_data};
    endfunction

    // Called at the negedge with inputs settled: predicts what the next edge commits.
    task automatic checkOutput();
        if (clk_en && rst) begin
            if (insn_valid && insn_ready) begin
                chk("pop_pc", insn_pc, exp_pc);
                chk("pop_data", insn_data, imem[exp_pc[ADDR_W-1:0]]);
                exp_pc = exp_pc + 1'b1;
                pops++;
            end
            if (icache_req) begin
                chk("req_addr", icache_read_addr, exp_fetch[ADDR_W-1:0]);
                exp_fetch = exp_fetch + 1'b1;
                reqs++;
            end
            if (redirect_valid) begin
                exp_pc    = redirect_pc;
                exp_fetch = redirect_pc;
            end
        end
    endtask

    task automatic tick();
        checkOutput();
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        if (rand_ready) insn_ready = ($urandom_range(0, 3) != 0);
        tick();
    endtask

    task automatic runUntilPops(input int target, input int budget, input string tag);
        int n = 0;
        while (pops < target && n < budget) begin
            applyStimulus();
            n++;
        end
        chk(tag, pops >= target, 1);
    endtask

    task automatic waitReq(input string tag);
        int n = 0;
        while (!icache_req && n < 60) begin
            applyStimulus();
            n++;
        end
        chk(tag, icache_req, 1);
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_req"}, icache_req, 0);
        chk({tag, "_addr"}, icache_read_addr, 0);
        chk({tag, "_valid"}, insn_valid, 0);
        chk({tag, "_pc"}, insn_pc, 0);
        chk({tag, "_data"}, insn_data, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = $urandom;

        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Decode stalled: exactly DEPTH reads, then fetch holds off.
        for (int i = 0; i < 30; i++) tick();
        chk("fill_reqs", reqs, FETCH_DEPTH);
        chk("fill_req_idle", icache_req, 0);
        chk("fill_valid", insn_valid, 1);
        insn_ready = 1'b1;
        runUntilPops(12, 200, "stream_pops");
        chk("stream_reqs_more", reqs > FETCH_DEPTH, 1);

        // Redirect while a slow read is in flight: that word must be drained.
        rand_ready = 1'b1;
        latency = 3;
        waitReq("redir_wait_req");
        redirect_valid = 1'b1;
        redirect_pc = PC_W'(40);
        tick();
        redirect_valid = 1'b0;
        chk("redir_flush", insn_valid, 0);
        runUntilPops(pops + 6, 300, "redir_pops");

        // Redirect in the same cycle as the data return.
        latency = 2;
        begin
            int n = 0;
            while (!icache_data_ready && n < 60) begin
                applyStimulus();
                n++;
            end
        end
        chk("same_cycle_ready", icache_data_ready, 1);
        redirect_valid = 1'b1;
        redirect_pc = PC_W'($urandom_range(100, 60000));
        tick();
        redirect_valid = 1'b0;
        chk("same_cycle_flush", insn_valid, 0);
        runUntilPops(pops + 6, 300, "same_cycle_pops");

        // Global stall: nothing moves for 5 cycles, then streaming resumes.
        latency = 1;
        runUntilPops(pops + 2, 100, "pre_stall_pops");
        clk_en = 1'b0;
        insn_ready = 1'b1;
        snap = outputs_now();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold", outputs_now(), snap);
        end
        clk_en = 1'b1;
        runUntilPops(pops + 6, 200, "post_stall_pops");

        // PC wrap from 16'hFFFF to 0 and icache address wrap 63 -> 0.
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFF;
        applyStimulus();
        redirect_valid = 1'b0;
        runUntilPops(pops + 4, 200, "wrap_pops");
        chk("wrap_model_pc", exp_pc, 16'd3);

        // Asynchronous reset asserted mid-read.
        waitReq("rst_wait_req");
        rst = 1'b0;
        #1;
        checkResetOutputs("async_rst");
        @(negedge clk);
        exp_pc = RESET_PC;
        exp_fetch = RESET_PC;
        rst = 1'b1;
        runUntilPops(pops + 3, 200, "post_rst_pops");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
